maxpool2x2_stream: RTL and testbench
====================================

# maxpool2x2_stream

Streaming 2×2, stride-2 max-pooling stage that sits directly downstream of the ReLU activation stage in the CNN datapath. Consumes one activation per valid beat in raster order (row-major, left to right, top to bottom) and emits one pooled value per 2×2 window. Horizontal pairs are reduced on the fly; an internal line buffer of IMG_W/2 entries holds even-row partial maxima. Output is registered, with a valid strobe and an end-of-frame pulse.

## Interface
- DATA_W, 13, activation width in bits; two's-complement signed compare.
- IMG_W, 28, input feature-map width in pixels; must be even and ≥2.
- IMG_H, 28, input feature-map height in pixels; must be even and ≥2.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clock clk.
- clear  input  1  synchronous frame restart; same effect as reset on the next edge.
- in_valid  input  1  in_data carries a pixel this cycle.
- in_data  input  DATA_W  activation pixel.
- out_valid  output  1  out_data carries a pooled result this cycle.
- out_data  output  DATA_W  pooled maximum.
- frame_done  output  1  one-cycle pulse coincident with the last out_valid of a frame.

## Operation
- Counters: col in 0..IMG_W-1 and row in 0..IMG_H-1 advance only on in_valid. col wraps to 0 and increments row. After (IMG_W-1, IMG_H-1), both wrap to 0 and the next pixel starts a new frame.
- Even col: in_data is latched into hold register h.
- Odd col: hmax = max(h, in_data), using a signed compare. Ties select either operand, since the values are equal.
- Even row, odd col: line_buf[col>>1] <= hmax. No output is produced.
- Odd row, odd col: result = max(line_buf[col>>1], hmax). It is registered into out_data and out_valid is set for one cycle.
- frame_done = out_valid for the window at row IMG_H-1, col IMG_W-1.
- Gaps in in_valid are legal at any point. State holds and no output is produced.
- Outputs per frame: exactly (IMG_W/2)·(IMG_H/2) out_valid pulses.
- No back-pressure. The downstream stage must accept out_valid in every cycle.
- Line buffer: IMG_W/2 × DATA_W entries. It may be registers or distributed RAM. Reads of an entry must return the value written on the even row of the same row pair.
- Width rule: no arithmetic beyond comparison, so out_data is always one of the four window inputs, bit-exact.

## Timing
- Reset values: out_valid=0, out_data=0, frame_done=0, col=0, row=0, h=0. Line buffer contents are don't-care; they are always written before being read.
- Latency: out_valid rises on the clk edge immediately after the edge that sampled the window's bottom-right pixel (1 cycle).
- out_valid and frame_done are single-cycle pulses. out_data holds its last value when out_valid=0.
- Throughput: one pixel per cycle sustained, with at most one output every 2 cycles.
- Reset asserted mid-frame: all outputs go to 0 asynchronously, and the next accepted pixel is (row 0, col 0).
- clear has the same result as reset, synchronously on the next edge. A pixel with in_valid in the same cycle as clear is discarded.
- Back-to-back frames: the first pixel of frame N+1 may arrive in the cycle after the last pixel of frame N. frame_done of frame N still fires.

## Test plan
- IMG_W=4, IMG_H=4, pixels 0..15 in raster order, continuous valid -> out_data 5, 7, 13, 15 with out_valid 1 cycle after pixels 5, 7, 13, 15. frame_done is set with the value 15 only.
- Signed compare: window {-3, -1, -7, -2} (13-bit two's complement, e.g. 0x1FFD) -> out_data = -1 (0x1FFF).
- Random in_valid gaps, about 50% duty, on the 0..15 frame -> the same four results. Each result appears exactly 1 cycle after its bottom-right pixel, and no spurious out_valid occurs.
- Reset asserted after pixel 9 of a frame, then a fresh 0..15 frame -> outputs are 0 immediately on reset, and the following frame yields 5, 7, 13, 15.
- Two frames back to back, the second being all 0x0FFF -> results 5, 7, 13, 15, then four results of 0x0FFF. frame_done pulses twice.
- Default 28×28 random frame checked against a software model -> 196 outputs, all matching, and one frame_done.

Source files
------------

// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream: streaming 2x2 / stride-2 max-pool over a raster-order
// activation stream. Horizontal pairs are reduced into a hold register,
// even-row pair maxima are parked in a half-width line buffer, and the odd
// row completes each window with a single registered output beat.
//
// Handshake: a pixel is consumed on every rising clk edge where in_valid=1
// (there is no ready; the source may insert idle cycles anywhere). A result
// is presented for exactly one cycle with out_valid=1 and there is no
// back-pressure, so the sink must take it in that cycle. out_data holds its
// last value while out_valid=0.
module maxpool2x2_stream #(
  parameter int DATA_W = 13,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              frame_done
);

  localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int IDX_W = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [DATA_W-1:0] h;
  logic [DATA_W-1:0] line_buf [IMG_W/2];

  logic              col_last;
  logic              row_last;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] hmax;
  logic [DATA_W-1:0] lb_rd;
  logic [DATA_W-1:0] win_max;
  logic              take;

  assign take     = in_valid && !clear;
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign idx      = IDX_W'(col >> 1);
  assign lb_rd    = line_buf[idx];

  // Signed pairwise reductions: horizontal pair, then vertical against the
  // even-row partial stored for this column pair. Ties pick either operand.
  always_comb begin
    hmax    = ($signed(in_data) > $signed(h))  ? in_data : h;
    win_max = ($signed(lb_rd)   > $signed(hmax)) ? lb_rd : hmax;
  end

  // Raster position counters; clear restarts the frame and drops the
  // pixel presented in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Hold register captures the left pixel of every horizontal pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h <= '0;
    end else if (clear) begin
      h <= '0;
    end else if (in_valid && !col[0]) begin
      h <= in_data;
    end
  end

  // Line buffer: even-row pair maxima, read back on the odd row of the
  // same row pair. Contents need no reset since every entry is written
  // before it is read.
  always_ff @(posedge clk) begin
    if (take && col[0] && !row[0]) begin
      line_buf[idx] <= hmax;
    end
  end

  // Registered output beat on each window's bottom-right pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else if (clear) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid && col[0] && row[0]) begin
        out_valid  <= 1'b1;
        out_data   <= win_max;
        frame_done <= col_last && row_last;
      end
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream: a 4x4 instance exercised with
// hand-computed frames, plus a default 28x28 instance checked against a
// plain 2-D max-of-window reference.
module tb_maxpool2x2_stream;

  localparam int W = 13;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  logic clear;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4x4 instance
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         frame_done;

  // 28x28 instance
  logic         in_valid28;
  logic [W-1:0] in_data28;
  logic         out_valid28;
  logic [W-1:0] out_data28;
  logic         frame_done28;

  maxpool2x2_stream #(.DATA_W(W), .IMG_W(4), .IMG_H(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  maxpool2x2_stream #(.DATA_W(W), .IMG_W(28), .IMG_H(28)) dut28 (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid28),
    .in_data    (in_data28),
    .out_valid  (out_valid28),
    .out_data   (out_data28),
    .frame_done (frame_done28)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] frame_px [16];
  logic [W-1:0] px28 [28][28];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] smax(input logic [W-1:0] a, input logic [W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // ---------------- driver tasks ----------------
  // Drives the first n_pix pixels of frame_px into the 4x4 instance, with
  // optional random idle cycles, and checks outputs 1 cycle after each pixel.
  task automatic run_frame(input int n_pix, input bit gaps);
    for (int i = 0; i < n_pix; i++) begin
      bit br;
      logic [W-1:0] e;
      if (gaps) begin
        int ng;
        ng = $urandom_range(0, 1);
        for (int g = 0; g < ng; g++) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_data  = W'($urandom);
          @(posedge clk);
          #1;
          check("gap_out_valid", out_valid, 0);
          check("gap_frame_done", frame_done, 0);
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = frame_px[i];
      @(posedge clk);
      #1;
      br = ((i / 4) % 2 == 1) && ((i % 4) % 2 == 1);
      check("out_valid", out_valid, br);
      if (br) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("out_data", out_data, e);
        check("frame_done", frame_done, (i == 15));
      end else begin
        check("frame_done_idle", frame_done, 0);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) frame_px[i] = W'(i);
  endtask

  task automatic push_ramp_results();
    exp_q.push_back(13'd5);
    exp_q.push_back(13'd7);
    exp_q.push_back(13'd13);
    exp_q.push_back(13'd15);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n_out28;
    int n_done28;
    reset      = 1'b1;
    clear      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_valid28 = 1'b0;
    in_data28  = '0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_frame_done", frame_done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Ramp frame, continuous valid
    load_ramp();
    push_ramp_results();
    run_frame(16, 0);

    // Signed comparisons
    frame_px = '{13'h1FFD, 13'h1FFF, 13'h1FFB, 13'h0003,
                 13'h1FF9, 13'h1FFE, 13'h1FF8, 13'h0001,
                 13'h1FFC, 13'h1FFA, 13'h0000, 13'h1FFF,
                 13'h1FFE, 13'h1FF7, 13'h1FFF, 13'h1FFF};
    exp_q.push_back(13'h1FFF);
    exp_q.push_back(13'h0003);
    exp_q.push_back(13'h1FFE);
    exp_q.push_back(13'h0000);
    run_frame(16, 0);

    // Ramp frame with random idle cycles
    load_ramp();
    push_ramp_results();
    run_frame(16, 1);

    // Reset after pixel 9, then a fresh frame
    exp_q.push_back(13'd5);
    exp_q.push_back(13'd7);
    run_frame(10, 0);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_out_data", out_data, 0);
    check("midreset_frame_done", frame_done, 0);
    @(negedge clk);
    reset = 1'b0;
    push_ramp_results();
    run_frame(16, 0);

    // Synchronous clear mid-frame discards the coincident pixel
    exp_q.push_back(13'd5);
    run_frame(6, 0);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 13'd15;
    @(posedge clk);
    #1;
    check("clear_out_valid", out_valid, 0);
    check("clear_out_data", out_data, 0);
    check("clear_frame_done", frame_done, 0);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    push_ramp_results();
    run_frame(16, 0);

    // Back-to-back frames, second all 0x0FFF
    push_ramp_results();
    for (int k = 0; k < 4; k++) exp_q.push_back(13'h0FFF);
    run_frame(16, 0);
    for (int i = 0; i < 16; i++) frame_px[i] = 13'h0FFF;
    run_frame(16, 0);
    check("exp_q_drained_4x4", exp_q.size(), 0);

    // Default 28x28 random frame against a 2-D reference
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++)
        px28[r][c] = W'($urandom_range(0, 8191));
    for (int wr = 0; wr < 14; wr++)
      for (int wc = 0; wc < 14; wc++)
        exp_q.push_back(smax(smax(px28[2*wr][2*wc], px28[2*wr][2*wc+1]),
                             smax(px28[2*wr+1][2*wc], px28[2*wr+1][2*wc+1])));
    n_out28  = 0;
    n_done28 = 0;
    for (int r = 0; r < 28; r++) begin
      for (int c = 0; c < 28; c++) begin
        bit br;
        logic [W-1:0] e;
        @(negedge clk);
        in_valid28 = 1'b1;
        in_data28  = px28[r][c];
        @(posedge clk);
        #1;
        br = (r % 2 == 1) && (c % 2 == 1);
        if (out_valid28) n_out28++;
        if (frame_done28) n_done28++;
        check("out_valid28", out_valid28, br);
        if (br) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
          check("out_data28", out_data28, e);
          check("frame_done28", frame_done28, (r == 27 && c == 27));
        end
      end
    end
    in_valid28 = 1'b0;
    @(posedge clk);
    #1;
    check("tail_out_valid28", out_valid28, 0);
    check("n_out28", n_out28, 196);
    check("n_done28", n_done28, 1);
    check("exp_q_drained_28", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
